// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction-fetch front end feeding the IF/ID register.
// Owns the PC, issues word fetches over a req/ack handshake, buffers returned
// words in a DEPTH-entry prefetch queue and presents {pc+4, inst} at the head.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   stall             IF/ID not accepting; head entry is held
//   redirect          taken branch; flush queue and refetch from redirect_pc
//   redirect_pc       branch target
//   imem_req/addr     registered fetch request and its word address
//   imem_ack/rdata    memory completes the request and returns the word
//   inst_valid        head entry valid
//   inst/inst_pc4     head instruction and its address + 4 (0 when empty)
//   fetch_pc          address of the next request to issue
//
// Optional feature: define FETCH_BYPASS_EN to hand a returning word straight
// to the outputs in its ack cycle when the queue is empty and IF/ID accepts.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc4,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               imem_req_q, imem_req_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        q_inst [DEPTH];
  logic [ADDR_W-1:0]  q_pc4  [DEPTH];

  logic               empty;
  logic               acked;
  logic               push;
  logic               pop;
  logic               issue;
  logic               bypass;
  logic [CNT_W-1:0]   count_nxt;
  logic [ADDR_W-1:0]  ack_pc4;

  assign empty   = (count_q == '0);
  assign acked   = imem_req_q & imem_ack;
  assign ack_pc4 = imem_addr_q + ADDR_W'(4);

  // A word may skip the queue only when nothing is ahead of it and IF/ID takes it now.
`ifdef FETCH_BYPASS_EN
  assign bypass = empty & ~stall & ~redirect & acked & (state_q == S_WAIT);
`else
  assign bypass = 1'b0;
`endif

  // Next-state logic: queue bookkeeping and request sequencing.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_addr_d = imem_addr_q;
    imem_req_d  = imem_req_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;
    issue       = 1'b0;
    count_nxt   = count_q;

    if (redirect) begin
      // Flush wins over stall and pop; an unacked request must drain in DISCARD.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      if (imem_req_q && !imem_ack) begin
        state_d = S_DISCARD;
      end else begin
        imem_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    end else begin
      pop       = ~empty & ~stall;
      push      = acked & (state_q == S_WAIT) & ~bypass;
      count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

      // Issue only if the new request can never overflow the queue.
      unique case (state_q)
        S_IDLE: begin
          if (count_nxt < CNT_W'(DEPTH)) issue = 1'b1;
        end
        S_WAIT: begin
          if (acked) begin
            if (count_nxt < CNT_W'(DEPTH)) begin
              issue = 1'b1;
            end else begin
              imem_req_d = 1'b0;
              state_d    = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (acked) issue = 1'b1;
        end
        default: begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      endcase

      if (issue) begin
        imem_req_d  = 1'b1;
        imem_addr_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + ADDR_W'(4);
        state_d     = S_WAIT;
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_nxt;
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr_q] <= imem_rdata;
      q_pc4[wr_ptr_q]  <= ack_pc4;
    end
  end

  // Head presentation; reads zero when nothing is available.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc4   = '0;
    if (!empty) begin
      inst_valid = 1'b1;
      inst       = q_inst[rd_ptr_q];
      inst_pc4   = q_pc4[rd_ptr_q];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc4   = ack_pc4;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign fetch_pc  = fetch_pc_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit against a transaction-level
// model: a queue of {pc4, inst} words, one outstanding-request slot and a
// discard flag, advanced once per clock edge from the behavioural rules.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic [31:0] fetch_pc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic        m_out;
  logic        m_disc;
  logic [31:0] m_addr;
  logic [31:0] m_fetch;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc4   (inst_pc4),
    .fetch_pc   (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_bypass();
    logic b;
    b = 1'b0;
`ifdef FETCH_BYPASS_EN
    b = (mq.size() == 0) && !stall && !redirect && m_out && !m_disc && imem_ack;
`endif
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out   = 1'b0;
    m_disc  = 1'b0;
    m_addr  = RST_PC;
    m_fetch = RST_PC;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic acked;
    logic byp;
    acked = m_out && imem_ack;
    if (redirect) begin
      mq.delete();
      m_fetch = redirect_pc;
      if (m_out && !acked) m_disc = 1'b1;
      else begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
    end else begin
      byp = model_bypass();
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (acked && !m_disc && !byp) mq.push_back({m_addr + 32'd4, mem_word(m_addr)});
      if (acked) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (!m_out && mq.size() < DEPTH) begin
        m_addr  = m_fetch;
        m_fetch = m_fetch + 32'd4;
        m_out   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic        byp;
    logic [63:0] head;
    byp = model_bypass();
    if (mq.size() > 0) head = mq[0];
    else if (byp)      head = {m_addr + 32'd4, mem_word(m_addr)};
    else               head = '0;
    check("imem_req",   64'(imem_req),   64'(m_out));
    check("imem_addr",  64'(imem_addr),  64'(m_addr));
    check("fetch_pc",   64'(fetch_pc),   64'(m_fetch));
    check("inst_valid", 64'(inst_valid), 64'((mq.size() > 0) || byp));
    check("inst",       64'(inst),       64'(head[31:0]));
    check("inst_pc4",   64'(inst_pc4),   64'(head[63:32]));
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc, input logic a);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_ack    = a;
    imem_rdata  = mem_word(m_addr);
    #1 compare_all();
    @(posedge clk);
    model_step();
  endtask

  // Asynchronous reset pulse between edges, then resume.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_imem_req",   64'(imem_req),   64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'(RST_PC));
    check("rst_fetch_pc",   64'(fetch_pc),   64'(RST_PC));
    check("rst_inst",       64'(inst),       64'd0);
    check("rst_inst_pc4",   64'(inst_pc4),   64'd0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_step();
    #2;
    check("rst_first_req",  64'(imem_req),  64'd1);
    check("rst_first_addr", 64'(imem_addr), 64'(RST_PC));
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(2))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
      default: return $urandom();
    endcase
  endfunction

  int unsigned stall_pct [6] = '{0, 20, 50, 80, 10, 40};
  int unsigned ack_pct   [6] = '{100, 70, 50, 90, 30, 60};
  int unsigned redir_pct [6] = '{0, 5, 10, 3, 15, 25};

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("por_imem_req",   64'(imem_req),   64'd0);
    check("por_inst_valid", 64'(inst_valid), 64'd0);
    check("por_fetch_pc",   64'(fetch_pc),   64'(RST_PC));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_step();

    // Stall held with ack tied high: the queue fills to DEPTH and requests stop.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    #2;
    check("stall_req_drop", 64'(imem_req),   64'd0);
    check("stall_valid",    64'(inst_valid), 64'd1);
    check("stall_head_pc4", 64'(inst_pc4),   64'(RST_PC + 32'd4));
    check("stall_head",     64'(inst),       64'(mem_word(RST_PC)));
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Redirect while a request is outstanding and its ack is delayed.
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    #2;
    check("redir_addr",  64'(imem_addr),  64'h100);
    check("redir_empty", 64'(inst_valid), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Redirect coinciding with an ack under stall: acked word is dropped.
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    #2;
    check("redir_ack_valid", 64'(inst_valid), 64'd0);
    check("redir_ack_req",   64'(imem_req),   64'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    #2;
    check("redir_ack_addr",  64'(imem_addr),  64'h200);

    // Randomized phases with varied stall/ack/redirect mixes.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(99) < stall_pct[p],
              $urandom_range(99) < redir_pct[p],
              rand_target(),
              $urandom_range(99) < ack_pct[p]);
      end
      // Leave a request hanging, then reset asynchronously mid-transaction.
      cycle(1'b0, 1'b0, '0, 1'b0);
      reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
